// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory between instruction fetch and data ports.
// Data has fixed priority; define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                grant_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
    // A waiting fetch wins once data has taken STARVE_MAX grants in a row.
    grant_data   = d_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIMIT));
`else
    grant_data   = d_req_i;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          ram_req_d   = 1'b1;
          ram_we_d    = d_we_i;
          ram_addr_d  = d_addr_i;
          ram_wdata_d = d_wdata_i;
          grant_d     = GNT_D;
          state_d     = BUSY_D;
`ifdef ARB_STARVE_GUARD_EN
          starve_cnt_d = if_req_i ? starve_cnt_q + 1'b1 : '0;
`endif
        end else if (if_req_i) begin
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr_i;
          grant_d    = GNT_IF;
          state_d    = BUSY_I;
`ifdef ARB_STARVE_GUARD_EN
          starve_cnt_d = '0;
`endif
        end
      end
      BUSY_I: begin
        if (ram_ack_i) begin
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
          if_rdata_d = ram_rdata_i;
          if_ready_d = 1'b1;
          state_d    = RESP;
        end
      end
      BUSY_D: begin
        if (ram_ack_i) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          if (!ram_we_q) d_rdata_d = ram_rdata_i;
          d_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;

endmodule
